// File: rtl/ahb_burst_master.sv
// AHB-Lite master: splits a byte-count command into 1KB-safe INCR16/INCR8/INCR4/SINGLE bursts; `AHB_M_LOCK_EN locks a command.
// Latency: first NONSEQ three cycles after cmd_req is sampled (IDLE->ACCEPT->PLAN); cmd_done one cycle after the last data phase.
// Backpressure: hready low freezes every AHB flop; write beats wait on wdata_valid (IDLE/BUSY); read data has no backpressure.
module ahb_burst_master #(
    parameter int ADDRW     = 32,
    parameter int DATAW     = 32,
    parameter int BYTE_CNTW = 16,
    parameter int MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_req,
    input  logic                 cmd_wr,
    input  logic [ADDRW-1:0]     cmd_addr,
    input  logic [BYTE_CNTW-1:0] cmd_byte_cnt,
    output logic                 cmd_ack,
    output logic                 cmd_done,
    output logic                 cmd_err,
    input  logic [DATAW-1:0]     wdata,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    output logic [DATAW-1:0]     rdata,
    output logic                 rdata_valid,
    output logic [ADDRW-1:0]     haddr,
    output logic                 hwrite,
    output logic [2:0]           hsize,
    output logic [2:0]           hburst,
    output logic [1:0]           htrans,
    output logic [3:0]           hprot,
    output logic                 hmastlock,
    output logic [DATAW-1:0]     hwdata,
    input  logic [DATAW-1:0]     hrdata,
    input  logic                 hready,
    input  logic                 hresp
);

    localparam int BPB    = DATAW / 8;
    localparam int BPB_LG = $clog2(BPB);
    localparam int BEATW  = BYTE_CNTW;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR4  = 3'b011;
    localparam logic [2:0] HB_INCR8  = 3'b101;
    localparam logic [2:0] HB_INCR16 = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_PLAN, S_XFER, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t             state, state_nxt;
    logic [ADDRW-1:0]   addr;
    logic [BEATW-1:0]   beats_left;
    logic [4:0]         burst_left;
    logic               wr;
    logic               err_flag;
    logic [DATAW-1:0]   wbuf;
    logic               dp_vld;
    logic               dp_wr;

    logic               issue, issue_first, err_hit, last_of_burst, data_ok;
    logic [1:0]         htrans_nxt;
    logic [10:0]        blk_off;
    logic [4:0]         plan_len;
    logic [2:0]         plan_burst;

    assign hsize = 3'(BPB_LG);
    assign hprot = 4'b0001;

    // A burst must end strictly inside the current 1KB block.
    assign blk_off = {1'b0, addr[9:0]};

    always_comb begin
        plan_len   = 5'd1;
        plan_burst = HB_SINGLE;
        if (MAX_BEATS >= 16 && beats_left >= BEATW'(16) && (blk_off + 11'(16 * BPB)) < 11'd1024) begin
            plan_len   = 5'd16;
            plan_burst = HB_INCR16;
        end else if (MAX_BEATS >= 8 && beats_left >= BEATW'(8) && (blk_off + 11'(8 * BPB)) < 11'd1024) begin
            plan_len   = 5'd8;
            plan_burst = HB_INCR8;
        end else if (beats_left >= BEATW'(4) && (blk_off + 11'(4 * BPB)) < 11'd1024) begin
            plan_len   = 5'd4;
            plan_burst = HB_INCR4;
        end
    end

    assign data_ok       = !wr || wdata_valid;
    assign last_of_burst = (state == S_PLAN) ? (plan_len == 5'd1) : (burst_left == 5'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        issue_first = 1'b0;
        err_hit     = 1'b0;
        htrans_nxt  = TR_IDLE;
        case (state)
            S_IDLE:   if (cmd_req) state_nxt = S_ACCEPT;
            S_ACCEPT: state_nxt = (beats_left == '0) ? S_DONE : S_PLAN;
            S_PLAN, S_XFER, S_DRAIN: begin
                if (dp_vld && hresp && !hready) begin
                    err_hit   = 1'b1;
                    state_nxt = S_ERR;
                end else if (hready) begin
                    if (state == S_DRAIN) begin
                        if (!htrans[1]) state_nxt = S_DONE;
                    end else if (data_ok) begin
                        issue       = 1'b1;
                        issue_first = (state == S_PLAN);
                        htrans_nxt  = issue_first ? TR_NONSEQ : TR_SEQ;
                        if (last_of_burst)
                            state_nxt = (beats_left == BEATW'(1)) ? S_DRAIN : S_PLAN;
                        else
                            state_nxt = S_XFER;
                    end else if (state == S_XFER) begin
                        htrans_nxt = TR_BUSY;
                    end
                end
            end
            S_ERR:   if (hready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cmd_ack     = (state == S_ACCEPT);
    assign cmd_done    = (state == S_DONE);
    assign cmd_err     = (state == S_DONE) && err_flag;
    assign wdata_ready = issue && wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr        <= '0;
            beats_left  <= '0;
            burst_left  <= '0;
            wr          <= 1'b0;
            err_flag    <= 1'b0;
            wbuf        <= '0;
            dp_vld      <= 1'b0;
            dp_wr       <= 1'b0;
            haddr       <= '0;
            hwrite      <= 1'b0;
            hburst      <= HB_SINGLE;
            htrans      <= TR_IDLE;
            hwdata      <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            if (state == S_IDLE && cmd_req) begin
                addr       <= {cmd_addr[ADDRW-1:BPB_LG], {BPB_LG{1'b0}}};
                beats_left <= cmd_byte_cnt >> BPB_LG;
                wr         <= cmd_wr;
                err_flag   <= 1'b0;
            end
            if (err_hit) begin
                // Two-cycle error response: withdraw the pipelined beat during the wait cycle.
                htrans   <= TR_IDLE;
                err_flag <= 1'b1;
            end else if (hready) begin
                htrans <= htrans_nxt;
                if (issue) begin
                    haddr      <= addr;
                    addr       <= addr + ADDRW'(BPB);
                    beats_left <= beats_left - BEATW'(1);
                    hwrite     <= wr;
                    wbuf       <= wdata;
                    if (issue_first) begin
                        hburst     <= plan_burst;
                        burst_left <= plan_len - 5'd1;
                    end else begin
                        burst_left <= burst_left - 5'd1;
                    end
                end else if (state == S_XFER) begin
                    haddr <= addr;
                end
                if (dp_vld && !dp_wr && !hresp) begin
                    rdata       <= hrdata;
                    rdata_valid <= 1'b1;
                end
                // The beat on the address bus is accepted now and becomes the data phase.
                dp_vld <= htrans[1];
                dp_wr  <= hwrite;
                if (htrans[1] && hwrite) hwdata <= wbuf;
            end
        end
    end

`ifdef AHB_M_LOCK_EN
    logic lock_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q <= 1'b0;
        end else if (hready) begin
            if (issue_first)              lock_q <= 1'b1;
            else if (state_nxt == S_DONE) lock_q <= 1'b0;
        end
    end

    assign hmastlock = lock_q;
`else
    assign hmastlock = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_burst_master.sv
// Randomised bench for ahb_burst_master: AHB slave with random wait states and error injection, write producer with gaps.
// Expected bursts, data and status come from a burst-splitting reference model working on plain integers and queues.
module tb_ahb_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_req, cmd_wr;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_byte_cnt;
    logic        cmd_ack, cmd_done, cmd_err;
    logic [31:0] wdata;
    logic        wdata_valid, wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata, hrdata;
    logic        hready, hresp;

    always #5 clk = ~clk;

    ahb_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_byte_cnt(cmd_byte_cnt),
        .cmd_ack(cmd_ack), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .htrans(htrans),
        .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

`ifdef AHB_M_LOCK_EN
    localparam logic LOCK_EXP = 1'b1;
`else
    localparam logic LOCK_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  tr;
        logic [2:0]  hb;
        logic        w;
    } ap_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    ap_t         obs_ap_q[$], exp_ap_q[$];
    logic [31:0] obs_wa_q[$], obs_wd_q[$], obs_rd_q[$], wbeats[$];

    // Bus-side state shared between the command task and the slave/producer process.
    int   err_beat = -1, err_stage = 0, stall_pct = 0, gap_pct = 0;
    int   ap_cnt = 0, dp_n = 0, wr_idx = 0;
    bit   wr_active = 0, saw_active = 0;
    bit   dp_v = 0, dp_w = 0, consumed = 0, hold_v = 0;
    logic [31:0] dp_a, hold_a;
    logic [1:0]  hold_t;

    // Reference burst split: greedy 16/8/4, burst must end strictly inside its 1KB block, else SINGLE.
    function automatic void build_exp(input logic [31:0] a0, input int beats, input logic w);
        logic [31:0] a;
        int left, len;
        ap_t e;
        a    = a0;
        left = beats;
        exp_ap_q.delete();
        while (left > 0) begin
            len = 1;
            if (left >= 16 && (a % 1024) + 64 < 1024)      len = 16;
            else if (left >= 8 && (a % 1024) + 32 < 1024)  len = 8;
            else if (left >= 4 && (a % 1024) + 16 < 1024)  len = 4;
            for (int i = 0; i < len; i++) begin
                e.a  = a + 32'(4 * i);
                e.tr = (i == 0) ? 2'b10 : 2'b11;
                e.hb = (len == 16) ? 3'b111 : (len == 8) ? 3'b101 : (len == 4) ? 3'b011 : 3'b000;
                e.w  = w;
                exp_ap_q.push_back(e);
            end
            a    = a + 32'(4 * len);
            left = left - len;
        end
    endfunction

    initial begin : bus
        ap_t o;
        hready = 1'b1; hresp = 1'b0; hrdata = '0; wdata = '0; wdata_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                dp_v = 0; hold_v = 0; consumed = 0;
            end else begin
                if (hold_v) check("stall_hold", {haddr, htrans}, {hold_a, hold_t});
                hold_v = !hready && !hresp && htrans != 2'b00;
                hold_a = haddr;
                hold_t = htrans;
                if (htrans != 2'b00) saw_active = 1;
                consumed = wdata_ready;
                if (wdata_ready) wr_idx++;
                if (rdata_valid) obs_rd_q.push_back(rdata);
                if (hready && dp_v) begin
                    if (dp_w && !hresp) begin
                        obs_wa_q.push_back(dp_a);
                        obs_wd_q.push_back(hwdata);
                    end
                    dp_v = 0;
                end
                if (hready && htrans[1]) begin
                    o.a = haddr; o.tr = htrans; o.hb = hburst; o.w = hwrite;
                    obs_ap_q.push_back(o);
                    check("lock", hmastlock, LOCK_EXP);
                    dp_v = 1; dp_a = haddr; dp_w = hwrite; dp_n = ap_cnt;
                    ap_cnt++;
                end
            end
            @(posedge clk);
            #1;
            if (err_stage == 1) begin
                hready = 1'b1; hresp = 1'b1; err_stage = 2;
            end else if (rst && dp_v && err_stage == 0 && dp_n == err_beat) begin
                hready = 1'b0; hresp = 1'b1; err_stage = 1;
            end else begin
                hresp  = 1'b0;
                hready = ($urandom_range(0, 99) >= stall_pct);
            end
            hrdata = (dp_v && !dp_w) ? pat(dp_a) : $urandom;
            if (!wr_active) begin
                wdata_valid = 1'b0;
            end else if (!wdata_valid || consumed) begin
                wdata_valid = 1'b0;
                if (wr_idx < wbeats.size() && $urandom_range(0, 99) >= gap_pct) begin
                    wdata_valid = 1'b1;
                    wdata       = wbeats[wr_idx];
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_htrans"}, htrans, 2'b00);
        check({tag, "_haddr"}, haddr, 32'h0);
        check({tag, "_hwrite"}, hwrite, 1'b0);
        check({tag, "_hburst"}, hburst, 3'b000);
        check({tag, "_hwdata"}, hwdata, 32'h0);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_pulses"}, {cmd_ack, cmd_done, cmd_err, rdata_valid, wdata_ready}, 5'b0);
        check({tag, "_hmastlock"}, hmastlock, 1'b0);
        check({tag, "_hsize"}, hsize, 3'd2);
        check({tag, "_hprot"}, hprot, 4'b0001);
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [15:0] cnt,
                           input int eb, input int stall, input int gap);
        int beats, n_acc, n_ok;
        bit acked, done;
        logic got_err;
        logic [31:0] a0;
        beats = int'(cnt) / 4;
        a0    = addr & ~32'h3;
        obs_ap_q.delete(); obs_wa_q.delete(); obs_wd_q.delete(); obs_rd_q.delete(); wbeats.delete();
        for (int i = 0; i < beats; i++) wbeats.push_back($urandom);
        build_exp(a0, beats, wr);
        ap_cnt = 0; err_stage = 0; err_beat = eb; stall_pct = stall; gap_pct = gap;
        wr_idx = 0; wr_active = wr; saw_active = 0;
        cmd_req = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_byte_cnt = cnt;
        acked = 0;
        for (int c = 0; c < 50 && !acked; c++) begin
            step();
            acked = cmd_ack;
        end
        check("cmd_ack", acked, 1'b1);
        cmd_req = 1'b0;
        done    = 0;
        got_err = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            step();
            done    = cmd_done;
            got_err = cmd_err;
        end
        check("cmd_done", done, 1'b1);
        check("cmd_err", got_err, eb >= 0);
        wr_active = 0;
        repeat (2) step();
        n_acc = (eb >= 0) ? eb + 1 : beats;
        n_ok  = (eb >= 0) ? eb : beats;
        check("addr_phase_cnt", obs_ap_q.size(), n_acc);
        for (int i = 0; i < obs_ap_q.size() && i < n_acc; i++)
            check("addr_phase", obs_ap_q[i], exp_ap_q[i]);
        check("wr_beat_cnt", obs_wa_q.size(), wr ? n_ok : 0);
        for (int i = 0; i < obs_wa_q.size() && i < n_ok; i++)
            check("wr_beat", {obs_wa_q[i], obs_wd_q[i]}, {a0 + 32'(4 * i), wbeats[i]});
        check("rd_beat_cnt", obs_rd_q.size(), wr ? 0 : n_ok);
        for (int i = 0; i < obs_rd_q.size() && i < n_ok; i++)
            check("rd_beat", obs_rd_q[i], pat(a0 + 32'(4 * i)));
        if (wr && eb < 0) check("wdata_consumed", wr_idx, beats);
        if (beats == 0) check("bus_stays_idle", saw_active, 1'b0);
    endtask

    initial begin : main
        bit w, seen_done, act;
        logic [31:0] a;
        logic [15:0] c;
        int nb, eb;
        rst = 1'b0; cmd_req = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_byte_cnt = '0;
        repeat (3) step();
        check_reset_vals("reset");
        rst = 1'b1;
        repeat (2) step();

        run_cmd(1'b1, 32'h100, 16'd64, -1, 0, 0);
        run_cmd(1'b0, 32'h3F0, 16'd96, -1, 0, 0);
        run_cmd(1'b1, 32'h000, 16'd32, -1, 0, 40);
        run_cmd(1'b0, 32'h040, 16'd16, -1, 40, 0);
        run_cmd(1'b1, 32'h800, 16'd64, 3, 0, 0);
        run_cmd(1'b0, 32'h500, 16'd64, 6, 20, 0);
        run_cmd(1'b0, 32'h010, 16'd3, -1, 0, 0);
        run_cmd(1'b0, 32'h3F6, 16'd22, -1, 10, 0);

        for (int n = 0; n < 12; n++) begin
            w  = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 4095);
            c  = 16'($urandom_range(0, 200));
            nb = int'(c) / 4;
            eb = -1;
            if (nb > 0 && $urandom_range(0, 3) == 0) eb = int'($urandom_range(0, nb - 1));
            run_cmd(w, a, c, eb, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
        end

        // Reset in the middle of a long read.
        err_beat = -1; err_stage = 0; stall_pct = 0; wr_active = 0;
        cmd_req = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h200; cmd_byte_cnt = 16'd64;
        for (int k = 0; k < 20 && !cmd_ack; k++) step();
        cmd_req = 1'b0;
        repeat (6) step();
        rst = 1'b0;
        step();
        check_reset_vals("midreset");
        rst = 1'b1;
        seen_done = 0;
        act       = 0;
        repeat (10) begin
            step();
            if (cmd_done) seen_done = 1;
            if (htrans != 2'b00) act = 1;
        end
        check("midreset_no_done", seen_done, 1'b0);
        check("midreset_bus_idle", act, 1'b0);

        run_cmd(1'b1, 32'h7F8, 16'd40, -1, 15, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
